// File: rtl/fir_pkg.sv
// Shared types and constants for the systolic complex FIR tile chain.
package fir_pkg;

    localparam int TAPS_PER_TILE = 4;
    localparam int DW            = 16;
    localparam int AW            = 40;

    // Index into the tap / delay-line arrays, and a counter wide enough for 0..TAPS_PER_TILE
    localparam int IDXW = $clog2(TAPS_PER_TILE);
    localparam int ACTW = $clog2(TAPS_PER_TILE + 1);

    // Tap count and config num are 8-bit fields on the chain
    localparam logic [7:0] TPT8 = 8'(TAPS_PER_TILE);

    typedef struct packed {
        logic signed [DW-1:0] data_r;
        logic signed [DW-1:0] data_i;
    } complex16_t;

    typedef struct packed {
        logic signed [AW-1:0] data_r;
        logic signed [AW-1:0] data_i;
    } complex_acc_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] num;
        logic       mode;
    } FIR_CONT_TO_TILE;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [7:0]  count;
    } FIR_TAP_LOAD;

    typedef struct packed {
        logic       valid;
        complex16_t data;
    } fir_sample_t;

    typedef struct packed {
        fir_sample_t  input_sample;
        complex_acc_t partial;
    } FIR_TILE_TO_TILE;

    // Sign-extend a full-precision product into the accumulator width
    function automatic logic signed [AW-1:0] sext_acc(input logic [2*DW-1:0] p);
        return {{(AW-2*DW){p[2*DW-1]}}, p};
    endfunction

endpackage

// File: rtl/fir_cmult.sv
// Combinational complex multiply, full 2*DW precision per component.
module fir_cmult
    import fir_pkg::*;
(
    input  complex16_t            tap,
    input  complex16_t            x,
    output logic [2*DW-1:0]       prod_r,
    output logic [2*DW-1:0]       prod_i
);

    logic signed [2*DW-1:0] tr, ti, xr, xi;
    logic signed [2*DW-1:0] rr, ii, ri, ir;

    // Widen operands first so the multiplies are evaluated at full product width
    always_comb begin
        tr = {{DW{tap.data_r[DW-1]}}, tap.data_r};
        ti = {{DW{tap.data_i[DW-1]}}, tap.data_i};
        xr = {{DW{x.data_r[DW-1]}}, x.data_r};
        xi = {{DW{x.data_i[DW-1]}}, x.data_i};
        rr = tr * xr;
        ii = ti * xi;
        ri = tr * xi;
        ir = ti * xr;
        prod_r = rr - ii;
        prod_i = ri + ir;
    end

endmodule

// File: rtl/fir_tap_tile.sv
// One cascadable tile of the systolic complex FIR: local taps, sample delay line,
// one-cycle partial-sum update, and forwarding of config/tap traffic downstream.
module fir_tap_tile
    import fir_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  FIR_CONT_TO_TILE cont_to_tile_in,
    output FIR_CONT_TO_TILE cont_to_tile_out,
    input  FIR_TAP_LOAD     tap_in,
    output FIR_TAP_LOAD     tap_out,
    input  FIR_TILE_TO_TILE from_prev_tile,
    output FIR_TILE_TO_TILE to_next_tile_out,
    input  logic [3:0]      scaling,
    input  logic            next_ready,
    output logic            ready
);

    complex16_t [TAPS_PER_TILE-1:0]          tap_q;
    complex16_t [TAPS_PER_TILE-1:0]          dly_q;
    complex16_t [TAPS_PER_TILE-1:0]          opnd;
    logic [TAPS_PER_TILE-1:0][2*DW-1:0]      prod_r;
    logic [TAPS_PER_TILE-1:0][2*DW-1:0]      prod_i;

    logic [ACTW-1:0]        active_q;
    logic                   mode_q;

    complex16_t             x;
    complex16_t             fwd_x;
    logic                   pass_thru;
    logic [IDXW-1:0]        out_sel;
    logic signed [AW-1:0]   sum_r, sum_i;
    logic signed [AW-1:0]   sh_r, sh_i;
    logic signed [AW-1:0]   part_r, part_i;
    logic [ACTW-1:0]        new_active;
    logic [7:0]             fwd_num;

    // Nothing is buffered here, so acceptance is just downstream readiness
    assign ready = next_ready;
    assign x     = from_prev_tile.input_sample.data;

    // Per-tap multiplier lanes: lane 0 sees the current sample, lane k the k-th previous one
    for (genvar k = 0; k < TAPS_PER_TILE; k++) begin : g_lane
        if (k == 0) begin : g_head
            assign opnd[k] = x;
        end else begin : g_tail
            assign opnd[k] = dly_q[k-1];
        end
        fir_cmult u_cmult (
            .tap    (tap_q[k]),
            .x      (opnd[k]),
            .prod_r (prod_r[k]),
            .prod_i (prod_i[k])
        );
    end

    // Sum only the active lanes, scale, and fold into the incoming partial
    always_comb begin
        sum_r = '0;
        sum_i = '0;
        for (int k = 0; k < TAPS_PER_TILE; k++) begin
            if (k < int'(active_q)) begin
                sum_r = sum_r + sext_acc(prod_r[k]);
                sum_i = sum_i + sext_acc(prod_i[k]);
            end
        end
        sh_r = sum_r >>> scaling;
        sh_i = sum_i >>> scaling;
        pass_thru = mode_q | (active_q == '0);
        if (pass_thru) begin
            part_r = from_prev_tile.partial.data_r;
            part_i = from_prev_tile.partial.data_i;
        end else begin
            part_r = from_prev_tile.partial.data_r + sh_r;
            part_i = from_prev_tile.partial.data_i + sh_i;
        end
    end

    // Forwarded sample: the one leaving position active-1, or the input itself when passing through
    always_comb begin
        out_sel = IDXW'(active_q - ACTW'(1));
        fwd_x   = pass_thru ? x : dly_q[out_sel];
    end

    // Split the tap budget: this tile keeps up to TAPS_PER_TILE, the rest goes downstream
    always_comb begin
        new_active = (cont_to_tile_in.num < TPT8) ? ACTW'(cont_to_tile_in.num) : ACTW'(TAPS_PER_TILE);
        fwd_num    = (cont_to_tile_in.num > TPT8) ? (cont_to_tile_in.num - TPT8) : 8'd0;
    end

    // State and output registers; everything freezes while downstream stalls
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tap_q            <= '0;
            dly_q            <= '0;
            active_q         <= '0;
            mode_q           <= 1'b0;
            cont_to_tile_out <= '0;
            tap_out          <= '0;
            to_next_tile_out <= '0;
        end else if (next_ready) begin
            cont_to_tile_out <= '0;
            tap_out          <= '0;
            to_next_tile_out <= '0;
            if (cont_to_tile_in.valid) begin
                // Reconfiguration wins; any sample/tap beat in the same cycle is dropped
                active_q               <= new_active;
                mode_q                 <= cont_to_tile_in.mode;
                tap_q                  <= '0;
                dly_q                  <= '0;
                cont_to_tile_out.valid <= 1'b1;
                cont_to_tile_out.num   <= fwd_num;
                cont_to_tile_out.mode  <= cont_to_tile_in.mode;
            end else begin
                if (tap_in.valid) begin
                    if (tap_in.count < TPT8) begin
                        tap_q[tap_in.count[IDXW-1:0]] <= tap_in.data;
                    end else begin
                        tap_out.valid <= 1'b1;
                        tap_out.data  <= tap_in.data;
                        tap_out.count <= tap_in.count - TPT8;
                    end
                end
                if (from_prev_tile.input_sample.valid) begin
                    dly_q                                <= {dly_q[TAPS_PER_TILE-2:0], x};
                    to_next_tile_out.input_sample.valid  <= 1'b1;
                    to_next_tile_out.input_sample.data   <= fwd_x;
                    to_next_tile_out.partial.data_r      <= part_r;
                    to_next_tile_out.partial.data_i      <= part_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_tile.sv
// Directed bench for fir_tap_tile: config split, tap routing, streaming sums,
// scaling, stall behaviour, bypass and zero-active pass-through.
module tb_fir_tap_tile;
    import fir_pkg::*;

    logic            clk;
    logic            rst_n;
    FIR_CONT_TO_TILE cont_to_tile_in, cont_to_tile_out;
    FIR_TAP_LOAD     tap_in, tap_out;
    FIR_TILE_TO_TILE from_prev_tile, to_next_tile_out;
    logic [3:0]      scaling;
    logic            next_ready;
    logic            ready;

    int n_vec = 0;
    int n_err = 0;

    fir_tap_tile dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cont_to_tile_in  (cont_to_tile_in),
        .cont_to_tile_out (cont_to_tile_out),
        .tap_in           (tap_in),
        .tap_out          (tap_out),
        .from_prev_tile   (from_prev_tile),
        .to_next_tile_out (to_next_tile_out),
        .scaling          (scaling),
        .next_ready       (next_ready),
        .ready            (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    // Apply a config beat for one cycle; its forwarded copy is visible on return
    task automatic send_cfg(input int num, input bit mode);
        cont_to_tile_in.valid = 1'b1;
        cont_to_tile_in.num   = 8'(num);
        cont_to_tile_in.mode  = mode;
        cyc();
        cont_to_tile_in = '0;
    endtask

    task automatic load_tap(input int idx, input int re, input int im);
        logic [15:0] r16, i16;
        r16 = 16'(re);
        i16 = 16'(im);
        tap_in.valid = 1'b1;
        tap_in.data  = {r16, i16};
        tap_in.count = 8'(idx);
        cyc();
        tap_in = '0;
    endtask

    task automatic set_x(input int re, input int im);
        from_prev_tile.input_sample.valid       = 1'b1;
        from_prev_tile.input_sample.data.data_r = 16'(re);
        from_prev_tile.input_sample.data.data_i = 16'(im);
    endtask

    task automatic set_part(input int re, input int im);
        from_prev_tile.partial.data_r = 40'(re);
        from_prev_tile.partial.data_i = 40'(im);
    endtask

    // Standard setup: active=2 with taps t0=3, t1=2 (real)
    task automatic setup_2tap;
        send_cfg(2, 1'b0);
        load_tap(1, 2, 0);
        load_tap(0, 3, 0);
    endtask

    function automatic int tn(input int n);
        return (n == 1) ? 3 : 5 * n - 2;
    endfunction

    initial begin
        cont_to_tile_in = '0;
        tap_in          = '0;
        from_prev_tile  = '0;
        scaling         = 4'd0;
        next_ready      = 1'b1;
        rst_n           = 1'b1;

        // Reset held with live inputs: outputs must stay zero
        cont_to_tile_in = '{valid: 1'b1, num: 8'd3, mode: 1'b0};
        set_x(5, 5);
        repeat (3) cyc();
        chk("rst_cont", cont_to_tile_out, 0);
        chk("rst_tap", tap_out, 0);
        chk("rst_out_vld", to_next_tile_out.input_sample.valid, 0);
        chk("rst_out_re", $signed(to_next_tile_out.partial.data_r), 0);
        next_ready = 1'b0;
        #1 chk("rst_ready0", ready, 0);
        next_ready = 1'b1;
        #1 chk("rst_ready1", ready, 1);
        cont_to_tile_in = '0;
        from_prev_tile  = '0;
        cyc();
        rst_n = 1'b0;
        cyc();

        // Config split
        send_cfg(6, 1'b0);
        chk("cfg6_vld", cont_to_tile_out.valid, 1);
        chk("cfg6_num", cont_to_tile_out.num, 2);
        chk("cfg6_mode", cont_to_tile_out.mode, 0);
        cyc();
        chk("cfg_idle", cont_to_tile_out.valid, 0);
        send_cfg(2, 1'b0);
        chk("cfg2_vld", cont_to_tile_out.valid, 1);
        chk("cfg2_num", cont_to_tile_out.num, 0);

        // Tap routing
        load_tap(1, 2, 0);
        chk("tap1_fwd", tap_out.valid, 0);
        load_tap(0, 3, 0);
        chk("tap0_fwd", tap_out.valid, 0);
        load_tap(5, 16'h1234, 16'h5678);
        chk("tap5_vld", tap_out.valid, 1);
        chk("tap5_cnt", tap_out.count, 1);
        chk("tap5_dat", tap_out.data, 32'h12345678);

        // Stream 1..64, scaling 0
        for (int n = 1; n <= 64; n++) begin
            set_x(n, 0);
            cyc();
            chk("s0_vld", to_next_tile_out.input_sample.valid, 1);
            chk("s0_re", $signed(to_next_tile_out.partial.data_r), tn(n));
            chk("s0_im", $signed(to_next_tile_out.partial.data_i), 0);
            chk("s0_fwd", $signed(to_next_tile_out.input_sample.data.data_r), (n >= 3) ? n - 2 : 0);
        end
        from_prev_tile.input_sample = '0;
        cyc();
        chk("idle_vld", to_next_tile_out.input_sample.valid, 0);
        chk("idle_re", $signed(to_next_tile_out.partial.data_r), 0);

        // Scaling 1
        setup_2tap();
        scaling = 4'd1;
        for (int n = 1; n <= 16; n++) begin
            set_x(n, 0);
            cyc();
            chk("s1_re", $signed(to_next_tile_out.partial.data_r), tn(n) >>> 1);
        end
        from_prev_tile.input_sample = '0;

        // Incoming partial added
        setup_2tap();
        scaling = 4'd0;
        set_part(100, -7);
        for (int n = 1; n <= 8; n++) begin
            set_x(n, 0);
            cyc();
            chk("p100_re", $signed(to_next_tile_out.partial.data_r), tn(n) + 100);
            chk("p100_im", $signed(to_next_tile_out.partial.data_i), -7);
        end
        from_prev_tile = '0;

        // Stall for 3 cycles mid-stream
        setup_2tap();
        for (int n = 1; n <= 5; n++) begin
            set_x(n, 0);
            cyc();
        end
        set_x(6, 0);
        next_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_re", $signed(to_next_tile_out.partial.data_r), 23);
            chk("stall_fwd", $signed(to_next_tile_out.input_sample.data.data_r), 3);
            chk("stall_rdy", ready, 0);
        end
        next_ready = 1'b1;
        for (int n = 6; n <= 8; n++) begin
            set_x(n, 0);
            cyc();
            chk("resume_re", $signed(to_next_tile_out.partial.data_r), tn(n));
            chk("resume_fwd", $signed(to_next_tile_out.input_sample.data.data_r), n - 2);
        end

        // Config collides with a sample: sample dropped, delay line cleared
        set_x(9, 0);
        send_cfg(2, 1'b0);
        from_prev_tile.input_sample = '0;
        chk("coll_cfg", cont_to_tile_out.valid, 1);
        chk("coll_vld", to_next_tile_out.input_sample.valid, 0);
        load_tap(1, 2, 0);
        load_tap(0, 3, 0);
        set_x(10, 0); cyc();
        chk("clr_re0", $signed(to_next_tile_out.partial.data_r), 30);
        chk("clr_fwd0", $signed(to_next_tile_out.input_sample.data.data_r), 0);
        set_x(11, 0); cyc();
        chk("clr_re1", $signed(to_next_tile_out.partial.data_r), 53);
        set_x(12, 0); cyc();
        chk("clr_re2", $signed(to_next_tile_out.partial.data_r), 58);
        chk("clr_fwd2", $signed(to_next_tile_out.input_sample.data.data_r), 10);
        from_prev_tile.input_sample = '0;

        // active=1, complex tap; tap[1] loaded but must be ignored
        send_cfg(1, 1'b0);
        chk("cfg1_num", cont_to_tile_out.num, 0);
        load_tap(0, 1, 2);
        load_tap(1, 9, 0);
        set_x(3, 4); cyc();
        chk("cx_re", $signed(to_next_tile_out.partial.data_r), -5);
        chk("cx_im", $signed(to_next_tile_out.partial.data_i), 10);
        chk("cx_fwd", $signed(to_next_tile_out.input_sample.data.data_r), 0);
        scaling = 4'd1;
        cyc();
        chk("cx_sh_re", $signed(to_next_tile_out.partial.data_r), -3);
        chk("cx_sh_im", $signed(to_next_tile_out.partial.data_i), 5);
        chk("cx_fwd_re", $signed(to_next_tile_out.input_sample.data.data_r), 3);
        chk("cx_fwd_im", $signed(to_next_tile_out.input_sample.data.data_i), 4);
        scaling = 4'd0;
        from_prev_tile.input_sample = '0;

        // Bypass
        send_cfg(4, 1'b1);
        chk("byp_num", cont_to_tile_out.num, 0);
        chk("byp_mode", cont_to_tile_out.mode, 1);
        load_tap(0, 3, 0);
        set_x(7, 5);
        set_part(50, -3);
        cyc();
        chk("byp_fwd_re", $signed(to_next_tile_out.input_sample.data.data_r), 7);
        chk("byp_fwd_im", $signed(to_next_tile_out.input_sample.data.data_i), 5);
        chk("byp_re", $signed(to_next_tile_out.partial.data_r), 50);
        chk("byp_im", $signed(to_next_tile_out.partial.data_i), -3);
        from_prev_tile = '0;

        // Zero active taps: pass-through
        send_cfg(0, 1'b0);
        chk("act0_num", cont_to_tile_out.num, 0);
        set_x(8, 0);
        set_part(11, 0);
        cyc();
        chk("act0_fwd", $signed(to_next_tile_out.input_sample.data.data_r), 8);
        chk("act0_re", $signed(to_next_tile_out.partial.data_r), 11);
        from_prev_tile = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
